prng_burst_gen: RTL and testbench
=================================

Name: prng_burst_gen

Overview:
- Parametrised pseudo-random generator; next generation of the 8-bit seeded generator used in the SRAM demo test paths.
- Selectable LCG or Galois-LFSR mode, generic width, single-step or counted-burst output with VALID/BUSY/DONE handshake.
- Feeds SRAM address/data pattern writers and checkers. Seed reload yields repeatable sequences for write-then-verify passes.

Parameters:
- WIDTH, 8, bit width of SEED and VAL.
- MODE, 0, generator type: 0 = LCG, 1 = Galois LFSR.
- LCG_A, 101, LCG multiplier; must be odd.
- LCG_C, 1, LCG increment; must be odd.
- LFSR_TAPS, 8'hB8, Galois feedback mask (WIDTH bits). The default is maximal-length for WIDTH=8.
- CNT_W, 8, width of BURST_LEN and the internal remaining-count register.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- LOAD  in  1  reload state from SEED.
- SEED  in  WIDTH  seed value; sampled on RST or LOAD.
- GET_NEXT  in  1  single-step request; honoured only in IDLE.
- START  in  1  burst request; honoured only in IDLE.
- BURST_LEN  in  CNT_W  number of values in a burst; sampled with START.
- STOP  in  1  abort a burst in progress.
- VAL  out  WIDTH  current generator state / output value.
- VALID  out  1  VAL holds a freshly generated value this cycle.
- BUSY  out  1  burst in progress.
- DONE  out  1  one-cycle pulse marking burst completion.

Behaviour:
- Priority at each edge: RST > LOAD > STOP > START/GET_NEXT.
- Seed sanitising: in MODE=1, a SEED of 0 is loaded as 1, which prevents LFSR lock-up. In MODE=0 the seed is loaded as-is.
- RST: VAL <= sanitised SEED, state IDLE, remaining count 0, VALID=BUSY=DONE=0.
  - RST mid-burst aborts the burst with no DONE.
- LOAD (any state): identical to RST.
  - LOAD mid-burst aborts the burst; VALID=BUSY=DONE=0 next cycle.
- next(v), MODE=0: (v*LCG_A + LCG_C) mod 2^WIDTH. Compute the full-width product, then truncate to the low WIDTH bits.
- next(v), MODE=1: v[0] ? ((v>>1) ^ LFSR_TAPS) : (v>>1).
- State machine: IDLE, RUN.
- IDLE:
  - VAL holds; VALID=BUSY=0.
  - GET_NEXT at edge t: VAL <= next(VAL). VALID=1 for exactly the cycle after t. DONE stays 0. State stays IDLE.
  - GET_NEXT held high steps every cycle.
  - START with BURST_LEN=N>0 at edge t0:
    - VAL <= next(VAL); remaining <= N-1.
    - VALID=BUSY=1 from the cycle after t0.
    - If N=1, DONE=1 in that same cycle and the state stays IDLE; otherwise go to RUN.
  - START with BURST_LEN=0: no advance, VALID=BUSY=0, DONE pulses for the single next cycle.
  - START and GET_NEXT together: START wins; GET_NEXT is ignored.
- RUN:
  - Each edge: VAL <= next(VAL), remaining--.
  - Edge where remaining goes 1 -> 0: last value produced; DONE=1 coincident with the last VALID; state -> IDLE.
  - Net effect: a burst of N gives VALID and BUSY high for exactly N consecutive cycles, N distinct successive values, and DONE high only in the Nth.
- START or GET_NEXT while BUSY: ignored; no re-trigger, no count change.
- STOP:
  - In RUN: at that edge, no advance; VAL holds its last value; VALID=BUSY=DONE=0; state IDLE.
  - STOP in IDLE: no effect.
  - STOP together with START in IDLE: STOP wins; no burst starts.
- DONE is never asserted by an abort (STOP, LOAD or RST).
- Wrap-around:
  - The LCG wraps mod 2^WIDTH.
  - The LFSR with the default taps has period 2^WIDTH-1 and never produces 0.
- Output register timing: VALID and DONE are registered, with no combinational paths from inputs to outputs.

Test Plan:
- MODE=0, WIDTH=8, SEED=3, RST, then GET_NEXT pulse x3 -> VAL = 48, 241, 22. Each step gives a one-cycle VALID; DONE stays 0.
- MODE=0, SEED=3, START with BURST_LEN=3 -> VALID/BUSY high 3 cycles with VAL = 48, 241, 22. DONE=1 only with 22. START pulsed mid-burst is ignored.
- MODE=1, SEED=8'h01, GET_NEXT held -> VAL = B8, 5C, 2E, ... Value 01 returns after exactly 255 steps; 00 is never produced.
- MODE=1, SEED=0 with RST -> VAL=01. Repeat the same with LOAD in IDLE -> VAL=01.
- Burst with BURST_LEN=10, STOP asserted on the 4th VALID cycle -> VAL frozen at the 4th value, VALID/BUSY drop next cycle, no DONE. A subsequent START with BURST_LEN=0 -> a single DONE pulse with no advance and no VALID.
- LOAD with SEED=3 mid-burst -> VAL=3 next cycle, IDLE, no DONE. Rerunning the burst reproduces 48, 241, 22 identically.

Source files
------------

// File: rtl/prng_burst_gen.sv
// Seeded pseudo-random generator (LCG or Galois LFSR) with single-step and
// counted-burst output, VALID/BUSY/DONE handshake for SRAM pattern paths.
module prng_burst_gen #(
   parameter int unsigned       WIDTH     = 8,
   parameter int unsigned       MODE      = 0,
   parameter int unsigned       LCG_A     = 101,
   parameter int unsigned       LCG_C     = 1,
   parameter logic [WIDTH-1:0]  LFSR_TAPS = WIDTH'(8'hB8),
   parameter int unsigned       CNT_W     = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             LOAD,
   input  logic [WIDTH-1:0] SEED,
   input  logic             GET_NEXT,
   input  logic             START,
   input  logic [CNT_W-1:0] BURST_LEN,
   input  logic             STOP,
   output logic [WIDTH-1:0] VAL,
   output logic             VALID,
   output logic             BUSY,
   output logic             DONE
);

   localparam logic [WIDTH-1:0] A_W = WIDTH'(LCG_A);
   localparam logic [WIDTH-1:0] C_W = WIDTH'(LCG_C);

   typedef enum logic {IDLE, RUN} state_e;

   state_e           state_q;
   logic [WIDTH-1:0] val_q;
   logic [CNT_W-1:0] cnt_q;
   logic             valid_q;
   logic             busy_q;
   logic             done_q;

   logic [WIDTH-1:0] lcg_c;
   logic [WIDTH-1:0] lfsr_c;
   logic [WIDTH-1:0] next_c;
   logic [WIDTH-1:0] seed_c;

   // Next-value generation; LCG arithmetic wraps naturally at WIDTH bits.
   always_comb begin
      lcg_c  = val_q * A_W + C_W;
      lfsr_c = val_q[0] ? ((val_q >> 1) ^ LFSR_TAPS) : (val_q >> 1);
      next_c = (MODE == 1) ? lfsr_c : lcg_c;
      seed_c = ((MODE == 1) && (SEED == '0)) ? WIDTH'(1) : SEED;
   end

   always_ff @(posedge CLK) begin
      if (RST || LOAD) begin
         state_q <= IDLE;
         val_q   <= seed_c;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               // The final burst cycle is IDLE but still BUSY: requests ignored.
               if (!STOP && !busy_q) begin
                  if (START) begin
                     if (BURST_LEN == '0) begin
                        done_q <= 1'b1;
                     end else begin
                        val_q   <= next_c;
                        cnt_q   <= BURST_LEN - CNT_W'(1);
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                        if (BURST_LEN == CNT_W'(1)) begin
                           done_q <= 1'b1;
                        end else begin
                           state_q <= RUN;
                        end
                     end
                  end else if (GET_NEXT) begin
                     val_q   <= next_c;
                     valid_q <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (STOP) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end else begin
                  val_q   <= next_c;
                  cnt_q   <= cnt_q - CNT_W'(1);
                  valid_q <= 1'b1;
                  busy_q  <= 1'b1;
                  if (cnt_q == CNT_W'(1)) begin
                     done_q  <= 1'b1;
                     state_q <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign VAL   = val_q;
   assign VALID = valid_q;
   assign BUSY  = busy_q;
   assign DONE  = done_q;

endmodule

// File: tb/tb_prng_burst_gen.sv
// Directed bench for prng_burst_gen: one LCG and one LFSR instance share stimulus.
module tb_prng_burst_gen;

   logic       clk = 1'b0;
   logic       rst, load, get_next, start, stop;
   logic [7:0] seed, burst_len;
   logic [7:0] val0, val1;
   logic       valid0, busy0, done0, valid1, busy1, done1;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   prng_burst_gen #(.WIDTH(8), .MODE(0)) dut_lcg (
      .CLK(clk), .RST(rst), .LOAD(load), .SEED(seed), .GET_NEXT(get_next),
      .START(start), .BURST_LEN(burst_len), .STOP(stop),
      .VAL(val0), .VALID(valid0), .BUSY(busy0), .DONE(done0)
   );

   prng_burst_gen #(.WIDTH(8), .MODE(1)) dut_lfsr (
      .CLK(clk), .RST(rst), .LOAD(load), .SEED(seed), .GET_NEXT(get_next),
      .START(start), .BURST_LEN(burst_len), .STOP(stop),
      .VAL(val1), .VALID(valid1), .BUSY(busy1), .DONE(done1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // VAL, VALID, BUSY, DONE of the LCG instance in one call.
   task automatic check_lcg(input string tag, input logic [7:0] v, input logic va,
                            input logic bu, input logic dn);
      check({tag, ".val"},   32'(val0),   32'(v));
      check({tag, ".valid"}, 32'(valid0), 32'(va));
      check({tag, ".busy"},  32'(busy0),  32'(bu));
      check({tag, ".done"},  32'(done0),  32'(dn));
   endtask

   task automatic do_reset(input logic [7:0] s);
      seed = s;
      rst  = 1'b1;
      tick();
      rst  = 1'b0;
   endtask

   logic [7:0] exp_lcg [3] = '{8'd48, 8'd241, 8'd22};
   logic [7:0] exp_lfsr[3] = '{8'hB8, 8'h5C, 8'h2E};

   initial begin
      int first_return;
      logic zero_seen;

      rst = 1'b1; load = 1'b0; get_next = 1'b0; start = 1'b0; stop = 1'b0;
      seed = 8'd3; burst_len = 8'd0;

      // Reset state and single-step LCG sequence.
      do_reset(8'd3);
      check_lcg("rst", 8'd3, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         get_next = 1'b1;
         tick();
         get_next = 1'b0;
         check_lcg($sformatf("step%0d", i), exp_lcg[i], 1'b1, 1'b0, 1'b0);
         tick();
         check_lcg($sformatf("step%0d_hold", i), exp_lcg[i], 1'b0, 1'b0, 1'b0);
      end

      // Burst of 3 with START re-pulsed mid-burst.
      do_reset(8'd3);
      start = 1'b1; burst_len = 8'd3;
      tick();
      start = 1'b0;
      check_lcg("burst0", 8'd48, 1'b1, 1'b1, 1'b0);
      start = 1'b1; burst_len = 8'd5;
      tick();
      start = 1'b0;
      check_lcg("burst1", 8'd241, 1'b1, 1'b1, 1'b0);
      tick();
      check_lcg("burst2", 8'd22, 1'b1, 1'b1, 1'b1);
      tick();
      check_lcg("burst_end", 8'd22, 1'b0, 1'b0, 1'b0);
      tick();
      check_lcg("burst_quiet", 8'd22, 1'b0, 1'b0, 1'b0);

      // LFSR full period with GET_NEXT held.
      do_reset(8'h01);
      check("lfsr_rst", 32'(val1), 32'h01);
      first_return = 0;
      zero_seen = 1'b0;
      get_next = 1'b1;
      for (int i = 1; i <= 255; i++) begin
         tick();
         if (i <= 3) check($sformatf("lfsr_step%0d", i), 32'(val1), 32'(exp_lfsr[i-1]));
         if (val1 == 8'h00) zero_seen = 1'b1;
         if (val1 == 8'h01 && first_return == 0) first_return = i;
      end
      check("lfsr_valid_held", 32'(valid1), 32'd1);
      get_next = 1'b0;
      check("lfsr_period", 32'(first_return), 32'd255);
      check("lfsr_no_zero", 32'(zero_seen), 32'd0);

      // Zero-seed sanitising: LFSR only.
      do_reset(8'h00);
      check("lfsr_rst_seed0", 32'(val1), 32'h01);
      check("lcg_rst_seed0", 32'(val0), 32'h00);
      do_reset(8'h55);
      seed = 8'h00; load = 1'b1;
      tick();
      load = 1'b0;
      check("lfsr_load_seed0", 32'(val1), 32'h01);
      check("lfsr_load_valid", 32'(valid1), 32'd0);

      // Single-value burst on the LFSR: DONE coincides with the only VALID.
      do_reset(8'h01);
      start = 1'b1; burst_len = 8'd1;
      tick();
      start = 1'b0;
      check("lfsr_n1_val", 32'(val1), 32'hB8);
      check("lfsr_n1_flags", 32'({valid1, busy1, done1}), 32'b111);
      tick();
      check("lfsr_n1_after", 32'({valid1, busy1, done1}), 32'b000);
      check("lfsr_n1_hold", 32'(val1), 32'hB8);

      // Burst of 10 stopped on its 4th value, then a zero-length burst.
      do_reset(8'd3);
      start = 1'b1; burst_len = 8'd10;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      check_lcg("stop_4th", 8'd175, 1'b1, 1'b1, 1'b0);
      stop = 1'b1;
      tick();
      stop = 1'b0;
      check_lcg("stop_after", 8'd175, 1'b0, 1'b0, 1'b0);
      tick();
      check_lcg("stop_quiet", 8'd175, 1'b0, 1'b0, 1'b0);
      start = 1'b1; burst_len = 8'd0;
      tick();
      start = 1'b0;
      check_lcg("len0", 8'd175, 1'b0, 1'b0, 1'b1);
      tick();
      check_lcg("len0_after", 8'd175, 1'b0, 1'b0, 1'b0);
      stop = 1'b1; start = 1'b1; burst_len = 8'd3;
      tick();
      stop = 1'b0; start = 1'b0;
      check_lcg("stop_start", 8'd175, 1'b0, 1'b0, 1'b0);

      // LOAD mid-burst, then rerun reproduces the sequence.
      do_reset(8'd3);
      start = 1'b1; burst_len = 8'd5;
      tick();
      start = 1'b0;
      tick();
      seed = 8'd3; load = 1'b1;
      tick();
      load = 1'b0;
      check_lcg("load_mid", 8'd3, 1'b0, 1'b0, 1'b0);
      tick();
      check_lcg("load_quiet", 8'd3, 1'b0, 1'b0, 1'b0);
      start = 1'b1; burst_len = 8'd3;
      tick();
      start = 1'b0;
      check_lcg("rerun0", 8'd48, 1'b1, 1'b1, 1'b0);
      tick();
      check_lcg("rerun1", 8'd241, 1'b1, 1'b1, 1'b0);
      tick();
      check_lcg("rerun2", 8'd22, 1'b1, 1'b1, 1'b1);
      tick();
      check_lcg("rerun_end", 8'd22, 1'b0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
